alu_issue_ctrl: RTL and testbench

- Initiator side of the 32-bit ALU interface. It accepts decoded MIPS instruction fields plus register operands over a valid/ready handshake.
- It translates opcode/funct into the 4-bit ALU OP, forms the A/B operands, and drives them to the ALU. After a programmable settle time it captures F and the flags, then returns the result over a second valid/ready handshake.
- It sits between the multi-cycle datapath control and the combinational ALU.

---
 rtl/alu_issue_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded MIPS ALU instruction at a time and returns the captured F/flags.
// Latency SETTLE+1 cycles from accept to out_valid (1 for illegal); result held until out_ready.
module alu_issue_ctrl #(
    parameter int SIZE   = 32,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [SIZE-1:0] rs_val,
    input  logic [SIZE-1:0] rt_val,
    input  logic [15:0]     imm,
    output logic [3:0]      alu_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    input  logic [SIZE-1:0] alu_f,
    input  logic            alu_zf,
    input  logic            alu_cf,
    input  logic            alu_of,
    input  logic            alu_sf,
    input  logic            alu_pf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] result,
    output logic [4:0]      flags,
    output logic            ovf_trap,
    output logic            illegal,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [SIZE-1:0] alu_a_q, alu_a_d;
    logic [SIZE-1:0] alu_b_q, alu_b_d;
    logic [SIZE-1:0] result_q, result_d;
    logic [4:0]      flags_q, flags_d;
    logic            ovf_trap_q, ovf_trap_d;
    logic            illegal_q, illegal_d;
    logic            trap_q, trap_d;

    logic            dec_legal;
    logic            dec_trap;
    logic [3:0]      dec_op;
    logic [SIZE-1:0] dec_a;
    logic [SIZE-1:0] dec_b;
    logic [SIZE-1:0] imm_sext;
    logic [SIZE-1:0] imm_zext;
    logic [SIZE-1:0] shamt_zext;

    assign imm_sext   = {{(SIZE-16){imm[15]}}, imm};
    assign imm_zext   = {{(SIZE-16){1'b0}}, imm};
    assign shamt_zext = {{(SIZE-5){1'b0}}, shamt};

    // Only ADD, SUB and ADDI raise a trap on signed overflow.
    always_comb begin
        dec_legal = 1'b1;
        dec_trap  = 1'b0;
        dec_op    = 4'd0;
        dec_a     = rs_val;
        dec_b     = rt_val;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h24: dec_op = 4'd0;
                    6'h25: dec_op = 4'd1;
                    6'h26: dec_op = 4'd2;
                    6'h27: dec_op = 4'd3;
                    6'h20: begin dec_op = 4'd4; dec_trap = 1'b1; end
                    6'h21: dec_op = 4'd4;
                    6'h22: begin dec_op = 4'd5; dec_trap = 1'b1; end
                    6'h23: dec_op = 4'd5;
                    6'h2A: dec_op = 4'd6;
                    6'h2B: dec_op = 4'd6;
                    6'h00: begin dec_op = 4'd7; dec_a = shamt_zext; end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_op = 4'd4; dec_b = imm_sext; dec_trap = 1'b1; end
            6'h09: begin dec_op = 4'd4; dec_b = imm_sext; end
            6'h0A: begin dec_op = 4'd6; dec_b = imm_sext; end
            6'h0B: begin dec_op = 4'd6; dec_b = imm_sext; end
            6'h0C: begin dec_op = 4'd0; dec_b = imm_zext; end
            6'h0D: begin dec_op = 4'd1; dec_b = imm_zext; end
            6'h0E: begin dec_op = 4'd2; dec_b = imm_zext; end
            6'h0F: begin dec_op = 4'd7; dec_a = SIZE'(16); dec_b = imm_zext; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_d = 1'b0;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        result_d   = result_q;
        flags_d    = flags_q;
        ovf_trap_d = ovf_trap_q;
        illegal_d  = illegal_q;
        trap_d     = trap_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (dec_legal) begin
                        alu_op_d = dec_op;
                        alu_a_d  = dec_a;
                        alu_b_d  = dec_b;
                        trap_d   = dec_trap;
                        cnt_d    = SETTLE_M1;
                        state_d  = EXEC;
                    end else begin
                        alu_op_d   = 4'd0;
                        alu_a_d    = '0;
                        alu_b_d    = '0;
                        result_d   = '0;
                        flags_d    = 5'd0;
                        ovf_trap_d = 1'b0;
                        illegal_d  = 1'b1;
                        trap_d     = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    result_d   = alu_f;
                    flags_d    = {alu_zf, alu_cf, alu_of, alu_sf, alu_pf};
                    ovf_trap_d = alu_of & trap_q;
                    illegal_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises one cycle after re-entering IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            in_ready_q <= 1'b0;
            alu_op_q   <= 4'd0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            result_q   <= '0;
            flags_q    <= 5'd0;
            ovf_trap_q <= 1'b0;
            illegal_q  <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            ovf_trap_q <= ovf_trap_d;
            illegal_q  <= illegal_d;
            trap_q     <= trap_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign ovf_trap  = ovf_trap_q;
    assign illegal   = illegal_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with SETTLE=1, one with SETTLE=3.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [15:0] imm = '0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, ovf_trap, illegal, busy;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_f, result;
    logic        alu_zf, alu_cf, alu_of, alu_sf, alu_pf;
    logic [4:0]  flags;

    logic        s3_in_valid = 1'b0, s3_out_ready = 1'b0;
    logic        s3_in_ready, s3_out_valid, s3_ovf_trap, s3_illegal, s3_busy;
    logic [3:0]  s3_alu_op;
    logic [31:0] s3_alu_a, s3_alu_b, s3_alu_f, s3_result;
    logic        s3_zf, s3_cf, s3_of, s3_sf, s3_pf;
    logic [4:0]  s3_flags;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {F, ZF, CF, OF, SF, PF}.
    function automatic logic [36:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] f;
        logic        cf, of;
        s = '0; f = '0; cf = 1'b0; of = 1'b0;
        case (op)
            4'd0: f = a & b;
            4'd1: f = a | b;
            4'd2: f = a ^ b;
            4'd3: f = ~(a | b);
            4'd4: begin
                s = {1'b0, a} + {1'b0, b}; f = s[31:0]; cf = s[32];
                of = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'd5: begin
                s = {1'b0, a} - {1'b0, b}; f = s[31:0]; cf = s[32];
                of = (a[31] != b[31]) && (f[31] != a[31]);
            end
            4'd6: f = {31'd0, $signed(a) < $signed(b)};
            4'd7: f = b << a[4:0];
            default: f = '0;
        endcase
        return {f, (f == 32'd0), cf, of, f[31], ~^f[7:0]};
    endfunction

    assign {alu_f, alu_zf, alu_cf, alu_of, alu_sf, alu_pf} = alu_model(alu_op, alu_a, alu_b);
    assign {s3_alu_f, s3_zf, s3_cf, s3_of, s3_sf, s3_pf}   = alu_model(s3_alu_op, s3_alu_a, s3_alu_b);

    alu_issue_ctrl #(.SIZE(32), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of), .alu_sf(alu_sf), .alu_pf(alu_pf),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags),
        .ovf_trap(ovf_trap), .illegal(illegal), .busy(busy)
    );

    alu_issue_ctrl #(.SIZE(32), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .alu_op(s3_alu_op), .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_f(s3_alu_f),
        .alu_zf(s3_zf), .alu_cf(s3_cf), .alu_of(s3_of), .alu_sf(s3_sf), .alu_pf(s3_pf),
        .out_valid(s3_out_valid), .out_ready(s3_out_ready), .result(s3_result), .flags(s3_flags),
        .ovf_trap(s3_ovf_trap), .illegal(s3_illegal), .busy(s3_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one request, then scrambles the fields after accept.
    task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                         output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        opcode = opc; funct = fn; shamt = sh; rs_val = rs; rt_val = rt; imm = im;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 6'h3F; funct = 6'h3F; shamt = 5'h1F;
        rs_val = 32'hDEADBEEF; rt_val = 32'hCAFEF00D; imm = 16'h5A5A;
    endtask

    task automatic run_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] im, input logic [3:0] e_op, input logic [31:0] e_a,
                          input logic [31:0] e_b, input logic [31:0] e_res, input logic [4:0] e_flags,
                          input logic e_trap, input logic e_ill);
        bit ok;
        issue(opc, fn, sh, rs, rt, im, ok);
        if (!ok) return;
        check({tag, "_op"}, {28'd0, alu_op}, {28'd0, e_op});
        check({tag, "_a"}, alu_a, e_a);
        check({tag, "_b"}, alu_b, e_b);
        if (e_ill) begin
            check({tag, "_vld_direct"}, {31'd0, out_valid}, 32'd1);
        end else begin
            check({tag, "_vld_exec"}, {31'd0, out_valid}, 32'd0);
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_a_held"}, alu_a, e_a);
        end
        check({tag, "_res"}, result, e_res);
        check({tag, "_flags"}, {27'd0, flags}, {27'd0, e_flags});
        check({tag, "_trap"}, {31'd0, ovf_trap}, {31'd0, e_trap});
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, e_ill});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy_late"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        bit ok;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        //      tag     opc    funct  sh  rs            rt            imm      op  a             b             result        flags     trap ill
        run_op("add",   6'h00, 6'h20, 0,  32'h7FFFFFFF, 32'h00000001, 16'h0,   4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00111, 1, 0);
        run_op("addu",  6'h00, 6'h21, 0,  32'h7FFFFFFF, 32'h00000001, 16'h0,   4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00111, 0, 0);
        run_op("sll",   6'h00, 6'h00, 4,  32'h0000DEAD, 32'h0000000F, 16'h0,   7,  32'h00000004, 32'h0000000F, 32'h000000F0, 5'b00001, 0, 0);
        run_op("lui",   6'h0F, 6'h00, 0,  32'h00000063, 32'h0,        16'h1234, 7, 32'h00000010, 32'h00001234, 32'h12340000, 5'b00001, 0, 0);
        run_op("addi",  6'h08, 6'h00, 0,  32'h00000005, 32'h0,        16'hFFFF, 4, 32'h00000005, 32'hFFFFFFFF, 32'h00000004, 5'b01000, 0, 0);
        run_op("ori",   6'h0D, 6'h00, 0,  32'h12340000, 32'h0,        16'hFFFF, 1, 32'h12340000, 32'h0000FFFF, 32'h1234FFFF, 5'b00001, 0, 0);
        run_op("ill_op",6'h3F, 6'h20, 0,  32'h11111111, 32'h22222222, 16'h0,   0,  32'h0,        32'h0,        32'h0,        5'b00000, 0, 1);
        run_op("sub",   6'h00, 6'h22, 0,  32'h80000000, 32'h00000001, 16'h0,   5,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00101, 1, 0);
        run_op("slt",   6'h00, 6'h2A, 0,  32'hFFFFFFFF, 32'h00000001, 16'h0,   6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000, 0, 0);
        run_op("ill_fn",6'h00, 6'h08, 0,  32'h33333333, 32'h44444444, 16'h0,   0,  32'h0,        32'h0,        32'h0,        5'b00000, 0, 1);
        run_op("slti",  6'h0A, 6'h00, 0,  32'h00000000, 32'h0,        16'hFFFF, 6, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 5'b10001, 0, 0);
        run_op("andi",  6'h0C, 6'h00, 0,  32'hFFFFFFFF, 32'h0,        16'h8001, 0, 32'hFFFFFFFF, 32'h00008001, 32'h00008001, 5'b00000, 0, 0);
        run_op("xor",   6'h00, 6'h26, 0,  32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0,   2,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 5'b10001, 0, 0);
        run_op("nor",   6'h00, 6'h27, 0,  32'h00000000, 32'h00000000, 16'h0,   3,  32'h0,        32'h0,        32'hFFFFFFFF, 5'b00011, 0, 0);

        // SETTLE=3 with backpressure and an ignored second request.
        @(negedge clk);
        check("s3_idle_rdy", {31'd0, s3_in_ready}, 32'd1);
        opcode = 6'h00; funct = 6'h20; rs_val = 32'd2; rt_val = 32'd3;
        s3_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s3_in_valid = 1'b0;
        rs_val = 32'd100;
        check("s3_busy", {31'd0, s3_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("s3_settle_vld", {31'd0, s3_out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("s3_vld", {31'd0, s3_out_valid}, 32'd1);
        check("s3_res", s3_result, 32'd5);
        check("s3_flags", {27'd0, s3_flags}, 32'b00001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s3_in_valid = (i == 1 || i == 2);
            check("s3_hold_vld", {31'd0, s3_out_valid}, 32'd1);
            check("s3_hold_res", s3_result, 32'd5);
            check("s3_hold_rdy", {31'd0, s3_in_ready}, 32'd0);
        end
        @(negedge clk);
        s3_in_valid = 1'b0;
        s3_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s3_out_ready = 1'b0;
        check("s3_vld_drop", {31'd0, s3_out_valid}, 32'd0);
        check("s3_rdy_late", {31'd0, s3_in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("s3_rdy_back", {31'd0, s3_in_ready}, 32'd1);
        check("s3_idle", {31'd0, s3_busy}, 32'd0);
        @(posedge clk);
        #1;
        check("s3_no_2nd", {31'd0, s3_out_valid}, 32'd0);

        // Asynchronous reset while the SETTLE=1 instance is in EXEC.
        issue(6'h00, 6'h22, 5'd0, 32'd9, 32'd4, 16'h0, ok);
        if (ok) begin
            check("pre_rst_busy", {31'd0, busy}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("arst_busy", {31'd0, busy}, 32'd0);
            check("arst_op", {28'd0, alu_op}, 32'd0);
            check("arst_a", alu_a, 32'd0);
            check("arst_b", alu_b, 32'd0);
            check("arst_res", result, 32'd0);
            check("arst_flags", {27'd0, flags}, 32'd0);
            check("arst_rdy", {31'd0, in_ready}, 32'd0);
            check("arst_vld", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("rel_rdy", {31'd0, in_ready}, 32'd1);
            for (int i = 0; i < 3; i++) begin
                check("rel_no_vld", {31'd0, out_valid}, 32'd0);
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
